apb_io_arbiter: RTL and testbench



---
 rtl/apb_io_arbiter_if.sv | 57 +++++
 rtl/apb_io_arbiter.sv | 142 ++++++++++++++
 tb/tb_apb_io_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_io_arbiter_if.sv
// Bundle for the two upstream APB masters, the shared downstream
// port and the arbiter status outputs.
interface apb_io_arbiter_if;
  logic [15:0] m0_paddr;
  logic [15:0] m1_paddr;
  logic [7:0]  m0_pwdata;
  logic [7:0]  m1_pwdata;
  logic        m0_pwrite;
  logic        m1_pwrite;
  logic        m0_psel;
  logic        m1_psel;
  logic        m0_penable;
  logic        m1_penable;
  logic [7:0]  m0_prdata;
  logic [7:0]  m1_prdata;
  logic        m0_pready;
  logic        m1_pready;

  logic [15:0] s_paddr;
  logic [7:0]  s_pwdata;
  logic        s_pwrite;
  logic        s_psel;
  logic        s_penable;
  logic [7:0]  s_prdata;
  logic        s_pready;

  logic        timeout;
  logic        grant;

  modport slave (
    input  m0_paddr, m1_paddr,
    input  m0_pwdata, m1_pwdata,
    input  m0_pwrite, m1_pwrite,
    input  m0_psel, m1_psel,
    input  m0_penable, m1_penable,
    output m0_prdata, m1_prdata,
    output m0_pready, m1_pready,
    output s_paddr, s_pwdata, s_pwrite,
    output s_psel, s_penable,
    input  s_prdata, s_pready,
    output timeout, grant
  );

  modport master (
    output m0_paddr, m1_paddr,
    output m0_pwdata, m1_pwdata,
    output m0_pwrite, m1_pwrite,
    output m0_psel, m1_psel,
    output m0_penable, m1_penable,
    input  m0_prdata, m1_prdata,
    input  m0_pready, m1_pready,
    input  s_paddr, s_pwdata, s_pwrite,
    input  s_psel, s_penable,
    output s_prdata, s_pready,
    input  timeout, grant
  );
endinterface

// File: rtl/apb_io_arbiter.sv
// Round-robin two-master APB arbiter with registered SETUP/ACCESS
// re-timing and a bounded ACCESS phase that ends with read data 0xFF.
module apb_io_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             n_rst,
  apb_io_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_paddr;
  logic [7:0]  r_pwdata;
  logic        r_pwrite;
  logic        r_psel;
  logic        r_penable;
  logic [7:0]  r_prdata0;
  logic [7:0]  r_prdata1;
  logic        r_pready0;
  logic        r_pready1;
  logic        r_timeout;
  logic        r_grant;
  logic        r_last;
  logic [7:0]  r_cnt;

  logic        w_req;
  logic        w_win;
  logic [15:0] w_paddr;
  logic [7:0]  w_pwdata;
  logic        w_pwrite;
  logic        w_fin;
  logic [7:0]  w_rdata;
  logic        w_unused_penable;

  assign w_req = bus.m0_psel | bus.m1_psel;

  // r_last resets to m1 so that m0 wins the first tie.
  always_comb begin
    w_win = 1'b0;
    unique case (1'b1)
      (bus.m0_psel & bus.m1_psel):  w_win = ~r_last;
      (~bus.m0_psel & bus.m1_psel): w_win = 1'b1;
      default:                      w_win = 1'b0;
    endcase
  end

  assign w_paddr  = w_win ? bus.m1_paddr  : bus.m0_paddr;
  assign w_pwdata = w_win ? bus.m1_pwdata : bus.m0_pwdata;
  assign w_pwrite = w_win ? bus.m1_pwrite : bus.m0_pwrite;

  assign w_fin   = bus.s_pready | (r_cnt == LP_LAST);
  assign w_rdata = bus.s_pready ? bus.s_prdata : 8'hFF;

  // Master penable is not needed: psel alone marks a request.
  assign w_unused_penable = bus.m0_penable ^ bus.m1_penable;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_prdata0 <= '0;
      r_prdata1 <= '0;
      r_pready0 <= 1'b0;
      r_pready1 <= 1'b0;
      r_timeout <= 1'b0;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_cnt     <= '0;
    end else begin
      r_pready0 <= 1'b0;
      r_pready1 <= 1'b0;
      r_timeout <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_grant  <= w_win;
            r_last   <= w_win;
            r_paddr  <= w_paddr;
            r_pwdata <= w_pwdata;
            r_pwrite <= w_pwrite;
            r_psel   <= 1'b1;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (w_fin) begin
            if (r_grant) begin
              r_prdata1 <= w_rdata;
              r_pready1 <= 1'b1;
            end else begin
              r_prdata0 <= w_rdata;
              r_pready0 <= 1'b1;
            end
            r_timeout <= ~bus.s_pready;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.s_paddr   = r_paddr;
  assign bus.s_pwdata  = r_pwdata;
  assign bus.s_pwrite  = r_pwrite;
  assign bus.s_psel    = r_psel;
  assign bus.s_penable = r_penable;
  assign bus.m0_prdata = r_prdata0;
  assign bus.m1_prdata = r_prdata1;
  assign bus.m0_pready = r_pready0;
  assign bus.m1_pready = r_pready1;
  assign bus.timeout   = r_timeout;
  assign bus.grant     = r_grant;

endmodule

// File: tb/tb_apb_io_arbiter.sv
// Directed bench for apb_io_arbiter: vector table for single
// arbitrations plus sequences for back-to-back, reset and ties.
module tb_apb_io_arbiter;

  logic clk = 1'b0;
  logic n_rst = 1'b1;

  always #5 clk = ~clk;

  apb_io_arbiter_if bus();

  apb_io_arbiter #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic        r0;
    logic        r1;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        w0;
    logic        w1;
    int          waits;
    logic [7:0]  rdata;
    logic        exp_gnt;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic        exp_wr;
    int          exp_done;
    logic [7:0]  exp_prd;
    logic        exp_to;
    logic        chk_rd;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus.m0_paddr   = '0;
    bus.m1_paddr   = '0;
    bus.m0_pwdata  = '0;
    bus.m1_pwdata  = '0;
    bus.m0_pwrite  = 1'b0;
    bus.m1_pwrite  = 1'b0;
    bus.m0_psel    = 1'b0;
    bus.m1_psel    = 1'b0;
    bus.m0_penable = 1'b0;
    bus.m1_penable = 1'b0;
    bus.s_prdata   = '0;
    bus.s_pready   = 1'b0;
  endtask

  // Slave answers after 'waits' ACCESS cycles; waits < 0 never answers.
  task automatic slave_step(input int waits,
                            input logic [7:0] rd,
                            inout int acc);
    bus.s_pready = 1'b0;
    if (bus.s_psel && bus.s_penable) begin
      bus.s_pready = (waits >= 0) && (acc == waits);
      bus.s_prdata = rd;
      acc++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int acc;
    int done_c;
    int to_cnt;
    int lose_rdy;
    logic [7:0] got_prd;
    logic [7:0] lose_prd;
    acc = 0;
    done_c = -1;
    to_cnt = 0;
    lose_rdy = 0;
    got_prd = '0;
    @(negedge clk);
    idle_inputs();
    bus.m0_psel   = v.r0;
    bus.m1_psel   = v.r1;
    bus.m0_paddr  = v.a0;
    bus.m1_paddr  = v.a1;
    bus.m0_pwdata = v.d0;
    bus.m1_pwdata = v.d1;
    bus.m0_pwrite = v.w0;
    bus.m1_pwrite = v.w1;
    lose_prd = v.exp_gnt ? bus.m0_prdata : bus.m1_prdata;
    for (int c = 1; c <= 20 && done_c < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk($sformatf("v%0d grant", idx), bus.grant, v.exp_gnt);
        chk($sformatf("v%0d setup", idx),
            {bus.s_psel, bus.s_penable}, 2'b10);
        chk($sformatf("v%0d s_paddr", idx), bus.s_paddr, v.exp_addr);
        chk($sformatf("v%0d s_pwdata", idx), bus.s_pwdata, v.exp_wdata);
        chk($sformatf("v%0d s_pwrite", idx), bus.s_pwrite, v.exp_wr);
      end
      if (bus.timeout) to_cnt++;
      if (v.exp_gnt ? bus.m0_pready : bus.m1_pready) lose_rdy++;
      if (v.exp_gnt ? bus.m1_pready : bus.m0_pready) begin
        done_c = c;
        got_prd = v.exp_gnt ? bus.m1_prdata : bus.m0_prdata;
        bus.m0_psel = 1'b0;
        bus.m1_psel = 1'b0;
      end
      slave_step(v.waits, v.rdata, acc);
    end
    chk($sformatf("v%0d done cycle", idx), done_c, v.exp_done);
    chk($sformatf("v%0d access cycles", idx), acc, v.exp_done - 2);
    chk($sformatf("v%0d timeout", idx), to_cnt, {31'd0, v.exp_to});
    chk($sformatf("v%0d loser pready", idx), lose_rdy, 0);
    if (v.chk_rd)
      chk($sformatf("v%0d prdata", idx), got_prd, v.exp_prd);
    chk($sformatf("v%0d loser prdata", idx),
        v.exp_gnt ? bus.m0_prdata : bus.m1_prdata, lose_prd);
    @(negedge clk);
    chk($sformatf("v%0d pulse end", idx),
        {bus.m0_pready, bus.m1_pready, bus.timeout}, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int n_set;
    int n_rdy;
    int p0;
    int p1;

    // Fields: r0 r1 a0 a1 d0 d1 w0 w1 waits rdata
    //         gnt addr wdata wr done prd to chk_rd
    vt[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 8'h00, 8'h00,
              1'b0, 1'b0, 0, 8'h5A,
              1'b0, 16'h0010, 8'h00, 1'b0, 3, 8'h5A, 1'b0, 1'b1};
    vt[1] = '{1'b0, 1'b1, 16'h0000, 16'h0200, 8'h00, 8'h22,
              1'b0, 1'b1, 1, 8'h00,
              1'b1, 16'h0200, 8'h22, 1'b1, 4, 8'h00, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 8'h00, 8'h00,
              1'b0, 1'b0, -1, 8'h00,
              1'b0, 16'h0020, 8'h00, 1'b0, 6, 8'hFF, 1'b1, 1'b1};
    vt[3] = '{1'b0, 1'b1, 16'h0000, 16'h0030, 8'h00, 8'h00,
              1'b0, 1'b0, 3, 8'h3C,
              1'b1, 16'h0030, 8'h00, 1'b0, 6, 8'h3C, 1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b1, 16'h0300, 16'h0310, 8'h00, 8'h00,
              1'b0, 1'b0, 0, 8'h77,
              1'b0, 16'h0300, 8'h00, 1'b0, 3, 8'h77, 1'b0, 1'b1};
    vt[5] = '{1'b1, 1'b1, 16'h0500, 16'h0400, 8'hAA, 8'h55,
              1'b1, 1'b0, 2, 8'h99,
              1'b1, 16'h0400, 8'h55, 1'b0, 5, 8'h99, 1'b0, 1'b1};
    vt[6] = '{1'b1, 1'b0, 16'h0600, 16'h0000, 8'h66, 8'h00,
              1'b1, 1'b0, -1, 8'h00,
              1'b0, 16'h0600, 8'h66, 1'b1, 6, 8'h00, 1'b1, 1'b0};

    idle_inputs();
    #2 n_rst = 1'b0;
    #1;
    chk("rst s_psel", bus.s_psel, 1'b0);
    chk("rst s_penable", bus.s_penable, 1'b0);
    chk("rst s_paddr", bus.s_paddr, 16'h0000);
    chk("rst s_pwdata", bus.s_pwdata, 8'h00);
    chk("rst s_pwrite", bus.s_pwrite, 1'b0);
    chk("rst m0_pready", bus.m0_pready, 1'b0);
    chk("rst m1_pready", bus.m1_pready, 1'b0);
    chk("rst m0_prdata", bus.m0_prdata, 8'h00);
    chk("rst m1_prdata", bus.m1_prdata, 8'h00);
    chk("rst timeout", bus.timeout, 1'b0);
    chk("rst grant", bus.grant, 1'b0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    // Simultaneous writes: m0 first after reset, m1 four cycles later.
    @(negedge clk);
    bus.m0_psel   = 1'b1;
    bus.m0_paddr  = 16'h0100;
    bus.m0_pwdata = 8'h11;
    bus.m0_pwrite = 1'b1;
    bus.m1_psel   = 1'b1;
    bus.m1_paddr  = 16'h0200;
    bus.m1_pwdata = 8'h22;
    bus.m1_pwrite = 1'b1;
    acc = 0;
    n_set = 0;
    p0 = -1;
    p1 = -1;
    for (int c = 1; c <= 12 && p1 < 0; c++) begin
      @(negedge clk);
      if (bus.s_psel && !bus.s_penable) begin
        if (n_set == 0) begin
          chk("A setup0 cycle", c, 1);
          chk("A setup0 addr", bus.s_paddr, 16'h0100);
          chk("A setup0 data", bus.s_pwdata, 8'h11);
        end else begin
          chk("A setup1 cycle", c, 5);
          chk("A setup1 addr", bus.s_paddr, 16'h0200);
          chk("A setup1 data", bus.s_pwdata, 8'h22);
        end
        n_set++;
        acc = 0;
      end
      if (bus.m0_pready && p0 < 0) begin
        p0 = c;
        bus.m0_psel = 1'b0;
      end
      if (bus.m1_pready && p1 < 0) begin
        p1 = c;
        bus.m1_psel = 1'b0;
      end
      slave_step(0, 8'h00, acc);
    end
    chk("A m0 pready cycle", p0, 3);
    chk("A m1 pready cycle", p1, 7);
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vt[i], i);

    // Reset in the middle of ACCESS abandons the transfer.
    @(negedge clk);
    idle_inputs();
    bus.m0_psel  = 1'b1;
    bus.m0_paddr = 16'h0700;
    @(negedge clk);
    @(negedge clk);
    chk("C in access", {bus.s_psel, bus.s_penable}, 2'b11);
    #2 n_rst = 1'b0;
    #1;
    chk("C rst psel/penable", {bus.s_psel, bus.s_penable}, 2'b00);
    chk("C rst pready", {bus.m0_pready, bus.m1_pready}, 2'b00);
    chk("C rst grant", bus.grant, 1'b0);
    chk("C rst m0_prdata", bus.m0_prdata, 8'h00);
    bus.m0_psel = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("C no pready after release", bus.m0_pready, 1'b0);

    // Continuous requests from both: grants alternate from m0.
    @(negedge clk);
    bus.m0_psel  = 1'b1;
    bus.m0_paddr = 16'h0800;
    bus.m1_psel  = 1'b1;
    bus.m1_paddr = 16'h0900;
    acc = 0;
    n_set = 0;
    n_rdy = 0;
    for (int c = 1; c <= 40 && n_rdy < 6; c++) begin
      @(negedge clk);
      if (bus.s_psel && !bus.s_penable) begin
        if (n_set < 6) begin
          chk($sformatf("B grant %0d", n_set), bus.grant,
              {31'd0, n_set[0]});
          chk($sformatf("B setup cycle %0d", n_set), c,
              1 + 4 * n_set);
        end
        n_set++;
        acc = 0;
      end
      if (bus.m0_pready || bus.m1_pready) n_rdy++;
      if (n_rdy == 6) begin
        bus.m0_psel = 1'b0;
        bus.m1_psel = 1'b0;
      end
      slave_step(0, 8'hC3, acc);
    end
    chk("B transfers", n_rdy, 6);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
